path_delay_probe: RTL and testbench
===================================

# path_delay_probe

Launch/capture controller driving the input of a single-path delay chain under test and observing its output. It toggles the path input, measures the clock cycles until the transition emerges at the path output, and repeats for a programmed number of trials. It reports pass/fail counts and min/max/last latency so that added delay or logic corruption in the chain (e.g. an inserted trigger/payload gate) shows up as a latency shift or as failures. It also supplies the constant-high and constant-low tie nets the chain consumes.

## Interface
- CNT_W, 16: width of the trial count and pass/fail counters.
- LAT_W, 8: width of the latency counter, timeout and latency results.
- EXP_INV, 0: 1 if the path under test inverts (expected output = path_in ^ 1).
- SETTLE_CYC, 4: consecutive matching cycles required before each launch.

- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request; accepted only in IDLE.
- num_trials  in  CNT_W  trial count, latched at accepted start.
- timeout  in  LAT_W  per-phase cycle limit, latched at accepted start; 0 means 2^LAT_W-1.
- path_out  in  1  output of path under test; asynchronous.
- path_in  out  1  registered drive into the path under test.
- vcc_o  out  1  constant 1.
- gnd_o  out  1  constant 0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at run completion.
- pass_cnt  out  CNT_W  trials whose transition arrived within timeout.
- fail_cnt  out  CNT_W  trials that timed out in SETTLE or WAIT.
- last_lat, min_lat, max_lat  out  LAT_W each  latency of the last, fastest and slowest passing trial.

## Operation
- path_out passes through a 2-flop synchronizer; `s` is the second flop. Expected value `e` = path_in ^ EXP_INV.
- States:
  - IDLE
  - SETTLE: count consecutive cycles with s == e; reaching SETTLE_CYC goes to LAUNCH. A mismatch resets the count. Reaching timeout cycles in SETTLE records a fail and goes to NEXT.
  - LAUNCH: one cycle; path_in toggles and the latency counter clears.
  - WAIT: the counter increments each cycle. On s == e, last_lat = counter, min/max update, pass_cnt++, go to NEXT. On counter == timeout without a match, fail_cnt++ and go to NEXT.
  - NEXT: increment the trial index. If it equals num_trials, go to DONE; otherwise go to SETTLE.
  - DONE: done=1 for one cycle, then IDLE.
- Accepted start clears pass_cnt, fail_cnt and last_lat, sets min_lat to all-ones and max_lat to 0, then enters SETTLE. With num_trials==0 it goes directly to DONE.
- path_in is not reset between trials; successive trials alternate rising and falling launches.
- start while busy is ignored. Results hold from done until the next accepted start.
- Counters saturate at all-ones; no wrap.
- A WAIT match and timeout in the same cycle counts as a pass.
- If no trial passes, min_lat stays all-ones and max_lat stays 0.

## Timing
- Reset values:
  - path_in=0, busy=0, done=0.
  - pass_cnt=fail_cnt=last_lat=max_lat=0, min_lat=all-ones.
  - vcc_o=1, gnd_o=0, synchronizer=0, state IDLE.
- Reset asserted mid-run aborts immediately to the reset values. There is no partial done.
- Latency is counted in rising edges after the LAUNCH edge, up to and including the edge at which `s` first equals `e`. A zero-delay path reads 2, the synchronizer depth.
- start at edge T: busy=1 after T. With num_trials==0, done=1 in the cycle after T+1 and busy drops with it.
- done asserts the cycle after the final NEXT. busy deasserts in the same cycle done asserts.

## Test plan
- Reset, no start: path_in=0, vcc_o=1, gnd_o=0, min_lat=all-ones, all other outputs 0 for 20 cycles.
- Bench path = path_in delayed 3 flops, EXP_INV=0, num_trials=4, timeout=20 -> pass_cnt=4, fail_cnt=0, min=max=last=5, path_in back to 0 at done.
- path_out stuck 0, num_trials=3, timeout=10:
  - trial 1 fails in WAIT; trials 2 and 3 fail in SETTLE;
  - result: fail_cnt=3, pass_cnt=0, min_lat=all-ones, done pulses once.
- Bench delays of 2, 6, 4 flops over 3 trials -> pass_cnt=3, min_lat=4, max_lat=8, last_lat=6.
- num_trials=0 -> done exactly 2 cycles after start, counters 0. A second start during busy in any other run has no effect.
- rst asserted during WAIT of trial 2 of 5 -> all reset values next cycle. A new start with num_trials=1 then completes with pass_cnt=1.

Source files
------------

// File: rtl/path_delay_probe.sv
// rtl/path_delay_probe.sv - launch/capture latency probe for a single-path delay chain under test.
// Toggles path_in, times the transition back through a 2-flop synchronizer, accumulates trial statistics.
module path_delay_probe #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LAT_W      = 8,
    parameter int unsigned EXP_INV    = 0,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_trials,
    input  logic [LAT_W-1:0] timeout,
    input  logic             path_out,
    output logic             path_in,
    output logic             vcc_o,
    output logic             gnd_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] min_lat,
    output logic [LAT_W-1:0] max_lat
);

    localparam int unsigned SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic               path_in_q, path_in_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [LAT_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   trial_q, trial_d;
    logic [LAT_W-1:0]   phase_q, phase_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic [LAT_W-1:0]   last_q, last_d;
    logic [LAT_W-1:0]   min_q, min_d;
    logic [LAT_W-1:0]   max_q, max_d;

    logic               match;
    logic [CNT_W-1:0]   trial_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign match     = (sync2_q == (path_in_q ^ (EXP_INV != 0)));
    assign trial_inc = trial_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        path_in_d = path_in_q;
        num_d     = num_q;
        tmo_d     = tmo_q;
        trial_d   = trial_q;
        phase_d   = phase_q;
        set_d     = set_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        last_d    = last_q;
        min_d     = min_q;
        max_d     = max_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_trials;
                    tmo_d   = (timeout == '0) ? '1 : timeout;
                    trial_d = '0;
                    phase_d = '0;
                    set_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    last_d  = '0;
                    min_d   = '1;
                    max_d   = '0;
                    // A zero-trial run still passes through NEXT so done lands one cycle later.
                    state_d = (num_trials == '0) ? S_NEXT : S_SETTLE;
                end
            end
            S_SETTLE: begin
                phase_d = phase_q + 1'b1;
                if (match && (set_q == SET_W'(SETTLE_CYC - 1))) begin
                    set_d   = '0;
                    state_d = S_LAUNCH;
                end else begin
                    set_d = match ? set_q + 1'b1 : '0;
                    if (phase_q == tmo_q) begin
                        fail_d  = sat_inc(fail_q);
                        state_d = S_NEXT;
                    end
                end
            end
            S_LAUNCH: begin
                path_in_d = ~path_in_q;
                phase_d   = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Match is tested first so an arrival on the timeout cycle still counts as a pass.
                if (match) begin
                    last_d  = phase_q;
                    pass_d  = sat_inc(pass_q);
                    if (phase_q < min_q) min_d = phase_q;
                    if (phase_q > max_q) max_d = phase_q;
                    state_d = S_NEXT;
                end else if (phase_q == tmo_q) begin
                    fail_d  = sat_inc(fail_q);
                    state_d = S_NEXT;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_NEXT: begin
                trial_d = trial_inc;
                phase_d = '0;
                set_d   = '0;
                state_d = ((trial_inc == num_q) || (num_q == '0)) ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            path_in_q <= 1'b0;
            num_q     <= '0;
            tmo_q     <= '0;
            trial_q   <= '0;
            phase_q   <= '0;
            set_q     <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            last_q    <= '0;
            min_q     <= '1;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= path_out;
            sync2_q   <= sync1_q;
            path_in_q <= path_in_d;
            num_q     <= num_d;
            tmo_q     <= tmo_d;
            trial_q   <= trial_d;
            phase_q   <= phase_d;
            set_q     <= set_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            last_q    <= last_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    assign path_in  = path_in_q;
    assign vcc_o    = 1'b1;
    assign gnd_o    = 1'b0;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign last_lat = last_q;
    assign min_lat  = min_q;
    assign max_lat  = max_q;

endmodule

// File: tb/tb_path_delay_probe.sv
// tb/tb_path_delay_probe.sv - self-checking bench for path_delay_probe with a trial-level reference model.
module tb_path_delay_probe;

    localparam int CNT_W = 16;
    localparam int LAT_W = 8;
    localparam logic [63:0] RESET_VEC = {3'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                         16'h0, 16'h0, 8'h0, 8'hff, 8'h0};

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_trials;
    logic [LAT_W-1:0] timeout;
    logic             path_out;
    logic             path_in;
    logic             vcc_o;
    logic             gnd_o;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [LAT_W-1:0] last_lat;
    logic [LAT_W-1:0] min_lat;
    logic [LAT_W-1:0] max_lat;

    path_delay_probe #(
        .CNT_W(CNT_W), .LAT_W(LAT_W), .EXP_INV(0), .SETTLE_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_trials(num_trials), .timeout(timeout),
        .path_out(path_out), .path_in(path_in), .vcc_o(vcc_o), .gnd_o(gnd_o),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .last_lat(last_lat), .min_lat(min_lat), .max_lat(max_lat)
    );

    always #5 clk = ~clk;

    // Bench-side chain under test: path_in delayed by d_cur flops, or a stuck net.
    logic [15:0] sr = '0;
    logic [3:0]  d_cur = 4'd0;
    logic        stuck_en = 1'b0;
    logic        stuck_val = 1'b0;
    int          dly[16];
    int          launches;
    logic        pin_prev = 1'b0;
    logic        model_p;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) sr <= {sr[14:0], path_in};

    always_comb begin
        path_out = 1'b0;
        if (stuck_en)         path_out = stuck_val;
        else if (d_cur == 0)  path_out = path_in;
        else                  path_out = sr[d_cur - 4'd1];
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Every cycle of stimulus passes through here; a path_in edge marks a launch and selects that trial's delay.
    task automatic tick();
        @(negedge clk);
        if (path_in !== pin_prev) begin
            if (launches < 16) d_cur = 4'(dly[launches]);
            launches++;
        end
        pin_prev = path_in;
    endtask

    task automatic idle(input int c, output int extra);
        extra = 0;
        for (int i = 0; i < c; i++) begin
            tick();
            if (done) extra++;
        end
    endtask

    task automatic model_run(input int n, input int tmo_eff, input bit stk, input logic sv,
                             output int ep, output int ef, output int el, output int emn, output int emx);
        int lat;
        ep = 0; ef = 0; el = 0; emn = 255; emx = 0;
        for (int k = 0; k < n; k++) begin
            if (stk) begin
                ef++;
                if (model_p == sv) model_p = ~model_p;
            end else begin
                lat = dly[k] + 2;
                if (lat <= tmo_eff) begin
                    ep++;
                    el = lat;
                    if (lat < emn) emn = lat;
                    if (lat > emx) emx = lat;
                end else begin
                    ef++;
                end
                model_p = ~model_p;
            end
        end
    endtask

    task automatic do_run(input string tag, input int n, input int tmo, input bit spur, output int cycles);
        bit seen;
        launches = 0;
        d_cur = 4'(dly[0]);
        start = 1'b1;
        num_trials = CNT_W'(n);
        timeout = LAT_W'(tmo);
        tick();
        check({tag, "_busy_after_start"}, {busy, done}, 2'b10);
        start = 1'b0;
        num_trials = CNT_W'($urandom);
        timeout = LAT_W'($urandom);
        seen = 0;
        cycles = 0;
        for (int i = 1; i <= 20000; i++) begin
            if (spur && i == 5) begin
                start = 1'b1;
                num_trials = '0;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                seen = 1;
                cycles = i;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic check_results(input string tag, input int ep, input int ef, input int el,
                                 input int emn, input int emx);
        check({tag, "_pass_cnt"}, pass_cnt, ep);
        check({tag, "_fail_cnt"}, fail_cnt, ef);
        check({tag, "_last_lat"}, last_lat, el);
        check({tag, "_min_lat"}, min_lat, emn);
        check({tag, "_max_lat"}, max_lat, emx);
        check({tag, "_path_in"}, path_in, model_p);
    endtask

    task automatic full_run(input string tag, input int n, input int tmo, input bit stk,
                            input logic sv, input bit spur);
        int ep, ef, el, emn, emx, cyc, extra;
        stuck_en = stk;
        stuck_val = sv;
        idle(12, extra);
        model_run(n, (tmo == 0) ? 255 : tmo, stk, sv, ep, ef, el, emn, emx);
        do_run(tag, n, tmo, spur, cyc);
        check_results(tag, ep, ef, el, emn, emx);
        idle(4, extra);
        check({tag, "_single_done"}, extra, 0);
    endtask

    initial begin
        int cyc, extra, n, tmo, maxd, ep, ef, el, emn, emx;
        bit stk, seen;
        logic sv;

        rst = 1'b1;
        start = 1'b0;
        num_trials = '0;
        timeout = '0;
        launches = 0;
        model_p = 1'b0;
        for (int k = 0; k < 16; k++) dly[k] = 3;
        repeat (3) tick();
        check("reset_asserted", {path_in, vcc_o, gnd_o, busy, done, pass_cnt, fail_cnt,
                                 last_lat, min_lat, max_lat}, RESET_VEC);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("reset_idle", {path_in, vcc_o, gnd_o, busy, done, pass_cnt, fail_cnt,
                                 last_lat, min_lat, max_lat}, RESET_VEC);
        end

        // Fixed 3-flop chain, four trials.
        full_run("delay3", 4, 20, 0, 1'b0, 0);
        check("delay3_path_in_low", path_in, 0);

        // Stuck-low output with a start ignored mid-run.
        full_run("stuck0", 3, 10, 1, 1'b0, 1);

        // Per-trial delays 2, 6, 4.
        dly[0] = 2; dly[1] = 6; dly[2] = 4;
        full_run("mixed", 3, 20, 0, 1'b0, 0);

        // Arrival exactly on the timeout cycle is a pass.
        for (int k = 0; k < 16; k++) dly[k] = 3;
        full_run("tmo_edge", 2, 5, 0, 1'b0, 0);

        // Zero trials: done two cycles after start.
        stuck_en = 1'b0;
        idle(4, extra);
        do_run("zero", 0, 7, 0, cyc);
        check("zero_done_latency", cyc, 1);
        check("zero_counts", {pass_cnt, fail_cnt, last_lat, min_lat, max_lat}, {32'h0, 8'h0, 8'hff, 8'h0});
        idle(4, extra);
        check("zero_single_done", extra, 0);

        // Reset during WAIT of trial 2 of 5.
        for (int k = 0; k < 16; k++) dly[k] = 3;
        idle(12, extra);
        launches = 0;
        d_cur = 4'd3;
        start = 1'b1;
        num_trials = 16'd5;
        timeout = 8'd20;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (launches == 2) begin
                seen = 1;
                break;
            end
        end
        check("midrst_reached_trial2", seen, 1);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_async", {path_in, vcc_o, gnd_o, busy, done, pass_cnt, fail_cnt,
                               last_lat, min_lat, max_lat}, RESET_VEC);
        tick();
        check("midrst_held", {path_in, vcc_o, gnd_o, busy, done, pass_cnt, fail_cnt,
                              last_lat, min_lat, max_lat}, RESET_VEC);
        rst = 1'b0;
        model_p = 1'b0;
        full_run("after_rst", 1, 20, 0, 1'b0, 0);

        // Randomized runs against the trial-level model.
        for (int r = 0; r < 8; r++) begin
            stk = ($urandom_range(0, 3) == 0);
            sv = 1'($urandom_range(0, 1));
            if (stk) begin
                n = $urandom_range(1, 4);
                tmo = $urandom_range(4, 12);
            end else begin
                n = $urandom_range(1, 5);
                maxd = 0;
                for (int k = 0; k < 16; k++) begin
                    dly[k] = (k < n) ? $urandom_range(0, 8) : dly[k - 1];
                    if (k < n && dly[k] > maxd) maxd = dly[k];
                end
                case ($urandom_range(0, 3))
                    0:       tmo = 0;
                    1:       tmo = maxd + 2;
                    default: tmo = maxd + 2 + $urandom_range(0, 10);
                endcase
                if (tmo != 0 && tmo < 4) tmo = 4;
            end
            full_run($sformatf("rand%0d", r), n, tmo, stk, sv, ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
